// File: rtl/ysyx_23060072_lsu_ctrl.sv
// ysyx_23060072_lsu_ctrl -- load/store unit controller with a private data memory.
//
// Accepts one load or store at a time, waits MEM_LAT cycles, then performs the
// memory access and issues a one-cycle response. Misaligned and illegal-size
// requests can fault immediately without touching memory.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   req_valid_i        request present; load_i / store_i pick the direction
//   size_i             00 byte, 01 half, 10 word, 11 illegal
//   unsigned_i         load zero-extend (1) or sign-extend (0)
//   base_i, offset_i   address operands, summed mod 2^32
//   wdata_i            store data, right-aligned
//   req_ready_o        high only in IDLE; request accepted when high with a valid request
//   hold_o             stall request to the pipeline controller
//   resp_valid_o       one-cycle completion pulse
//   rdata_o            load result, zero unless a non-faulted load response
//   misalign_o         fault flag, valid with resp_valid_o
module ysyx_23060072_lsu_ctrl #(
  parameter int DEPTH       = 1024,
  parameter int MEM_LAT     = 1,
  parameter int CHECK_ALIGN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  input  logic        load_i,
  input  logic        store_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] base_i,
  input  logic [31:0] offset_i,
  input  logic [31:0] wdata_i,
  output logic        req_ready_o,
  output logic        hold_o,
  output logic        resp_valid_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [2:0] CNT_LAST = 3'(MEM_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [1:0]      lane_q, lane_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic            ld_q, ld_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            mis_q, mis_d;

  logic [3:0][7:0] mem [DEPTH];

  logic [31:0]     addr;
  logic            addr_unused;
  logic            req_ok, misal, accept, mem_go;
  logic [5:0]      sh;
  logic [3:0]      mask, strb;
  logic [31:0]     wrot, rword, rrot, ldata;

  assign addr        = base_i + offset_i;
  // Bits above the word index alias onto the same memory words.
  assign addr_unused = ^addr[31:AW+2];

  // Illegal size always faults; alignment is only enforced when CHECK_ALIGN is set.
  assign misal = (size_i == 2'b11) ||
                 ((CHECK_ALIGN != 0) &&
                  (((size_i == 2'b01) && addr[0]) ||
                   ((size_i == 2'b10) && (addr[1:0] != 2'b00))));

  assign req_ok = req_valid_i & (load_i | store_i);
  assign accept = rst_n & (state_q == S_IDLE) & req_ok;
  assign mem_go = rst_n & (state_q == S_WAIT) & (cnt_q == CNT_LAST);

  // Lane rotation: a misaligned access wraps around within the addressed word,
  // so strobes, store data and load data are all rotated by the byte lane.
  always_comb begin
    sh    = {1'b0, lane_q, 3'b000};
    case (size_q)
      2'b00:   mask = 4'b0001;
      2'b01:   mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
    strb  = (mask << lane_q) | (mask >> (3'd4 - {1'b0, lane_q}));
    wrot  = (wdata_q << sh) | (wdata_q >> (6'd32 - sh));
    rword = mem[idx_q];
    rrot  = (rword >> sh) | (rword << (6'd32 - sh));
    case (size_q)
      2'b00:   ldata = uns_q ? {24'd0, rrot[7:0]}  : {{24{rrot[7]}}, rrot[7:0]};
      2'b01:   ldata = uns_q ? {16'd0, rrot[15:0]} : {{16{rrot[15]}}, rrot[15:0]};
      default: ldata = rrot;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    size_d  = size_q;
    uns_d   = uns_q;
    ld_d    = ld_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    case (state_q)
      S_IDLE: begin
        if (req_ok) begin
          idx_d   = addr[AW+1:2];
          lane_d  = addr[1:0];
          size_d  = size_i;
          uns_d   = unsigned_i;
          ld_d    = load_i;     // load wins when both are set
          wdata_d = wdata_i;
          cnt_d   = 3'd0;
          rdata_d = 32'd0;
          if (misal) begin
            state_d = S_RESP;
            mis_d   = 1'b1;
          end else begin
            state_d = S_WAIT;
            mis_d   = 1'b0;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_RESP;
          cnt_d   = 3'd0;
          rdata_d = ld_q ? ldata : 32'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        rdata_d = 32'd0;
        mis_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      idx_q   <= '0;
      lane_q  <= 2'd0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      ld_q    <= 1'b0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      ld_q    <= ld_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

  // Memory is deliberately outside the reset domain; mem_go is already
  // qualified by rst_n so a reset during WAIT suppresses the write.
  always_ff @(posedge clk) begin
    if (mem_go && !ld_q) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) mem[idx_q][b] <= wrot[8*b +: 8];
      end
    end
  end

  // Outputs are forced quiet while reset is asserted.
  assign req_ready_o  = rst_n & (state_q == S_IDLE);
  assign hold_o       = accept | (rst_n & (state_q == S_WAIT));
  assign resp_valid_o = rst_n & (state_q == S_RESP);
  assign rdata_o      = resp_valid_o ? rdata_q : 32'd0;
  assign misalign_o   = resp_valid_o & mis_q;

endmodule

// File: tb/tb_ysyx_23060072_lsu_ctrl.sv
module tb_ysyx_23060072_lsu_ctrl;
  localparam int ML = 2;
  localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10, SX = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i, load_i, store_i, unsigned_i;
  logic [1:0]  size_i;
  logic [31:0] base_i, offset_i, wdata_i;
  logic        req_ready_o, hold_o, resp_valid_o, misalign_o;
  logic [31:0] rdata_o;

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  ysyx_23060072_lsu_ctrl #(.DEPTH(1024), .MEM_LAT(ML), .CHECK_ALIGN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .load_i(load_i), .store_i(store_i),
    .size_i(size_i), .unsigned_i(unsigned_i),
    .base_i(base_i), .offset_i(offset_i), .wdata_i(wdata_i),
    .req_ready_o(req_ready_o), .hold_o(hold_o), .resp_valid_o(resp_valid_o),
    .rdata_o(rdata_o), .misalign_o(misalign_o)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // One request from IDLE through its response; inputs are scrambled right
  // after acceptance so the in-flight access must rely on latched values.
  task automatic xfer(input string tag, input logic ld, input logic st,
                      input logic [1:0] sz, input logic un,
                      input logic [31:0] b, input logic [31:0] o, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_mis, input int exp_lat);
    int n;
    bit got;
    @(negedge clk);
    req_valid_i = 1'b1; load_i = ld; store_i = st; size_i = sz; unsigned_i = un;
    base_i = b; offset_i = o; wdata_i = wd;
    #1;
    chk({tag, ".ready"}, 32'(req_ready_o), 32'd1);
    chk({tag, ".hold_acc"}, 32'(hold_o), 32'd1);
    @(posedge clk);
    #1;
    req_valid_i = 1'b0; load_i = 1'b0; store_i = 1'b0; size_i = ~sz; unsigned_i = ~un;
    base_i = 32'h5A5A_5A5A; offset_i = 32'h0000_0101; wdata_i = ~wd;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (resp_valid_o) got = 1'b1;
      else chk({tag, ".hold_wait"}, 32'(hold_o), 32'd1);
    end
    if (!got) begin
      chk({tag, ".timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, ".lat"}, 32'(n), 32'(exp_lat));
      chk({tag, ".rdata"}, rdata_o, exp_rd);
      chk({tag, ".mis"}, 32'(misalign_o), 32'(exp_mis));
      chk({tag, ".resp_rdy"}, {31'd0, req_ready_o, hold_o}, 32'd0);
      @(negedge clk);
      chk({tag, ".pulse"}, {30'd0, resp_valid_o, req_ready_o}, 32'd1);
    end
  endtask

  initial begin
    int n;
    bit got;
    rst_n = 1'b0; req_valid_i = 1'b0; load_i = 1'b0; store_i = 1'b0;
    size_i = SW; unsigned_i = 1'b0; base_i = '0; offset_i = '0; wdata_i = '0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.outs", {rdata_o[30:0], resp_valid_o}, 32'd0);
    chk("rst.flags", {30'd0, misalign_o, hold_o}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst.ready", 32'(req_ready_o), 32'd1);

    // Word store/load round trip
    xfer("sw10", 0, 1, SW, 0, 32'h8, 32'h8, 32'hDEAD_BEEF, 32'h0, 0, ML+1);
    xfer("lw10", 1, 0, SW, 0, 32'h10, 32'h0, 32'h0, 32'hDEAD_BEEF, 0, ML+1);

    // Byte store into a word, signed/unsigned byte loads
    xfer("sw10b", 0, 1, SW, 0, 32'h10, 32'h0, 32'h1122_3344, 32'h0, 0, ML+1);
    xfer("sb13", 0, 1, SB, 0, 32'h10, 32'h3, 32'h1234_5680, 32'h0, 0, ML+1);
    xfer("lb13", 1, 0, SB, 0, 32'h10, 32'h3, 32'h0, 32'hFFFF_FF80, 0, ML+1);
    xfer("lbu13", 1, 0, SB, 1, 32'h13, 32'h0, 32'h0, 32'h0000_0080, 0, ML+1);
    xfer("lb12", 1, 0, SB, 0, 32'h12, 32'h0, 32'h0, 32'h0000_0022, 0, ML+1);
    xfer("lw10b", 1, 0, SW, 0, 32'h10, 32'h0, 32'h0, 32'h8022_3344, 0, ML+1);

    // Half loads/stores
    xfer("sw10h", 0, 1, SW, 0, 32'h10, 32'h0, 32'h8001_1234, 32'h0, 0, ML+1);
    xfer("lh12", 1, 0, SH, 0, 32'h12, 32'h0, 32'h0, 32'hFFFF_8001, 0, ML+1);
    xfer("lhu12", 1, 0, SH, 1, 32'h12, 32'h0, 32'h0, 32'h0000_8001, 0, ML+1);
    xfer("sh12", 0, 1, SH, 0, 32'h12, 32'h0, 32'h5555_ABCD, 32'h0, 0, ML+1);
    xfer("lw10h", 1, 0, SW, 0, 32'h10, 32'h0, 32'h0, 32'hABCD_1234, 0, ML+1);
    xfer("lh10", 1, 0, SH, 0, 32'h10, 32'h0, 32'h0, 32'h0000_1234, 0, ML+1);

    // Faults: one-cycle response, no memory effect
    xfer("lw02", 1, 0, SW, 0, 32'h0, 32'h2, 32'h0, 32'h0, 1, 1);
    xfer("sw12", 0, 1, SW, 0, 32'h12, 32'h0, 32'hFFFF_FFFF, 32'h0, 1, 1);
    xfer("sh11", 0, 1, SH, 0, 32'h11, 32'h0, 32'hFFFF_FFFF, 32'h0, 1, 1);
    xfer("lx10", 1, 0, SX, 0, 32'h10, 32'h0, 32'h0, 32'h0, 1, 1);
    xfer("lw10f", 1, 0, SW, 0, 32'h10, 32'h0, 32'h0, 32'hABCD_1234, 0, ML+1);

    // Load and store both set acts as a load
    xfer("ldst", 1, 1, SW, 0, 32'h10, 32'h0, 32'h0, 32'hABCD_1234, 0, ML+1);
    xfer("lw10ls", 1, 0, SW, 0, 32'h10, 32'h0, 32'h0, 32'hABCD_1234, 0, ML+1);

    // Valid without direction is ignored
    @(negedge clk);
    req_valid_i = 1'b1; load_i = 1'b0; store_i = 1'b0;
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (!req_ready_o || hold_o || resp_valid_o) n++;
    end
    chk("nodir.ignored", 32'(n), 32'd0);
    req_valid_i = 1'b0;

    // Address aliasing and 32-bit wrap of base+offset
    xfer("sw1000", 0, 1, SW, 0, 32'h1000, 32'h0, 32'hCAFE_F00D, 32'h0, 0, ML+1);
    xfer("lw0", 1, 0, SW, 0, 32'h0, 32'h0, 32'h0, 32'hCAFE_F00D, 0, ML+1);
    xfer("lb3", 1, 0, SB, 0, 32'h3, 32'h0, 32'h0, 32'hFFFF_FFCA, 0, ML+1);
    xfer("lwwrap", 1, 0, SW, 0, 32'hFFFF_FFFC, 32'h14, 32'h0, 32'hABCD_1234, 0, ML+1);

    // Reset on the last WAIT cycle aborts the store
    xfer("sw20", 0, 1, SW, 0, 32'h20, 32'h0, 32'h1111_1111, 32'h0, 0, ML+1);
    @(negedge clk);
    req_valid_i = 1'b1; load_i = 1'b0; store_i = 1'b1; size_i = SW;
    base_i = 32'h20; offset_i = 32'h0; wdata_i = 32'h2222_2222;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0; store_i = 1'b0;
    repeat (ML) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstw.outs", {rdata_o[29:0], resp_valid_o, misalign_o}, 32'd0);
    chk("rstw.hold", {30'd0, hold_o, req_ready_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (4) begin
      #1;
      if (resp_valid_o) n++;
      @(negedge clk);
    end
    chk("rstw.noresp", 32'(n), 32'd0);
    xfer("lw20", 1, 0, SW, 0, 32'h20, 32'h0, 32'h0, 32'h1111_1111, 0, ML+1);

    // Back-to-back: request held valid across the whole transaction
    @(negedge clk);
    req_valid_i = 1'b1; load_i = 1'b1; store_i = 1'b0; size_i = SW;
    base_i = 32'h10; offset_i = 32'h0;
    @(posedge clk);
    n = 0;
    for (int i = 1; i <= ML + 1; i++) begin
      @(negedge clk);
      if (req_ready_o) n++;
    end
    chk("b2b.busy", 32'(n), 32'd0);
    chk("b2b.rd1", rdata_o, 32'hABCD_1234);
    @(negedge clk);
    chk("b2b.idle", {30'd0, req_ready_o, hold_o}, 32'd3);
    @(posedge clk);
    #1;
    req_valid_i = 1'b0; load_i = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (resp_valid_o) got = 1'b1;
    end
    chk("b2b.lat2", 32'(n), 32'(ML + 1));
    chk("b2b.rd2", rdata_o, 32'hABCD_1234);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_23060072_lsu_ctrl.md
YSYX_23060072_LSU_CTRL -- requirements
Module: ysyx_23060072_lsu_ctrl

Interface
REQ-001 Parameter DEPTH, default 1024, data memory depth in 32-bit words; power of two, >= 4.
REQ-002 Parameter MEM_LAT, default 1, memory wait cycles per access; legal range 1..7.
REQ-003 Parameter CHECK_ALIGN, default 1; 1 = trap misaligned accesses, 0 = perform misaligned accesses wrapped within the word.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req_valid_i  input  1  request present.
REQ-007 load_i  input  1  request is a load.
REQ-008 store_i  input  1  request is a store.
REQ-009 size_i  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-010 unsigned_i  input  1  load extension: 0 sign-extend, 1 zero-extend.
REQ-011 base_i  input  32  address base operand.
REQ-012 offset_i  input  32  address offset operand.
REQ-013 wdata_i  input  32  store data, right-aligned.
REQ-014 req_ready_o  output  1  request accepted this cycle when high with req_valid_i.
REQ-015 hold_o  output  1  pipeline stall request to controller.
REQ-016 resp_valid_o  output  1  one-cycle completion pulse.
REQ-017 rdata_o  output  32  load result; valid with resp_valid_o.
REQ-018 misalign_o  output  1  access fault; valid with resp_valid_o.

Function
REQ-019 Address = base_i + offset_i, mod 2^32; word index = addr[log2(DEPTH)+1:2]; upper bits ignored (aliasing wrap-around); lane = addr[1:0].
REQ-020 FSM states IDLE, WAIT, RESP; req_ready_o = 1 only in IDLE.
REQ-021 IDLE -> WAIT on req_valid_i & (load_i | store_i) & aligned; address, size, unsigned, wdata, direction latched at acceptance.
REQ-022 IDLE -> RESP directly with misalign_o = 1 when CHECK_ALIGN = 1 and request misaligned (half with addr[0] = 1, word with addr[1:0] != 0) or size_i = 11; no memory access.
REQ-023 size_i = 11 always faults, regardless of CHECK_ALIGN.
REQ-024 req_valid_i with neither load_i nor store_i is ignored; load_i & store_i both high treated as load.
REQ-025 WAIT holds a counter for MEM_LAT cycles; memory read/write occurs on the last WAIT cycle edge; WAIT -> RESP then.
REQ-026 RESP lasts exactly one cycle, resp_valid_o = 1, then -> IDLE; next request acceptable the cycle after RESP.
REQ-027 Latency: acceptance edge to resp_valid_o high = MEM_LAT + 1 cycles (aligned), 1 cycle (faulted).
REQ-028 Stores use per-byte write strobes (byte: 1 lane, half: 2 lanes, word: 4); untouched bytes keep prior value; no read-modify-write.
REQ-029 With CHECK_ALIGN = 0, misaligned lanes wrap within the addressed word (half at lane 3 writes/reads lanes 3 and 0).
REQ-030 Load rdata_o: selected lanes right-aligned, sign- or zero-extended per latched unsigned flag; word loads unextended.
REQ-031 rdata_o = 0 whenever resp_valid_o = 0, for stores, and for faulted responses.
REQ-032 hold_o = 1 in IDLE when a request is being accepted, and throughout WAIT; 0 in RESP and idle IDLE.
REQ-033 Inputs changing after acceptance have no effect on the in-flight access.

Reset
REQ-034 rst_n low: state IDLE, counter 0, resp_valid_o 0, rdata_o 0, misalign_o 0, hold_o 0, req_ready_o 1 after release.
REQ-035 Reset mid-WAIT aborts the access: no memory write occurs, no response issued.
REQ-036 Memory contents are not cleared by reset.

Verification
REQ-037 Word store 0xDEADBEEF to addr 0x10, then word load 0x10 -> resp_valid_o MEM_LAT+1 cycles after each acceptance, rdata_o = 0xDEADBEEF.
REQ-038 Byte store 0x80 to 0x13 over word 0x11223344, signed byte load 0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; word load 0x10 -> 0x80223344.
REQ-039 Half load at 0x12 of word 0x8001_0000, signed -> 0xFFFF8001; half store 0xABCD at 0x12 leaves bytes 0x10-0x11 unchanged.
REQ-040 CHECK_ALIGN = 1, word load at 0x02 -> 1 cycle later resp_valid_o = 1, misalign_o = 1, rdata_o = 0; memory unchanged.
REQ-041 Store with rst_n pulsed low during WAIT -> following load of same address returns old data; outputs zero during reset.
REQ-042 DEPTH = 1024, store to 0x1000 aliases 0x0000; back-to-back requests held valid -> req_ready_o low in WAIT/RESP, second accepted in next IDLE cycle.
